// File: rtl/pipeline_with_axi_lite.sv
// Two-stage elastic stream pipeline computing (sample + COEF) mod 2^DATA_W,
// with an AXI4-Lite slave exposing ID, VERSION, STATS and COEF.
module pipeline_with_axi_lite #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter logic [31:0] ID_VALUE      = 32'h5049504C,
    parameter logic [31:0] VERSION_VALUE = 32'h00010000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready
);

    localparam logic [ADDR_W-1:0] ADDR_ID      = ADDR_W'(32'h0);
    localparam logic [ADDR_W-1:0] ADDR_VERSION = ADDR_W'(32'h4);
    localparam logic [ADDR_W-1:0] ADDR_STATS   = ADDR_W'(32'h8);
    localparam logic [ADDR_W-1:0] ADDR_COEF    = ADDR_W'(32'hC);
    localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(32'h3);

    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              bvalid_q, bvalid_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [DATA_W-1:0] coef_q, coef_d;
    logic [31:0]       stats_q, stats_d;
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              en_c;
    logic              unused_c;

    // Byte strobes and the bits above COEF carry no information here.
    assign unused_c = ^{s_axi_wstrb, s_axi_wdata[31:DATA_W]};

    function automatic logic [31:0] read_mux(input logic [ADDR_W-1:0] addr,
                                             input logic [31:0]       stats,
                                             input logic [DATA_W-1:0] coef);
        logic [31:0] val;
        val = 32'h0;
        case (addr & WORD_MASK)
            ADDR_ID:      val = ID_VALUE;
            ADDR_VERSION: val = VERSION_VALUE;
            ADDR_STATS:   val = stats;
            ADDR_COEF:    val = 32'(coef);
            default:      val = 32'h0;
        endcase
        return val;
    endfunction

    assign en_c = !s2_valid_q || m_axis_tready;

    // Next-state logic for the register interface and the pipeline.
    always_comb begin
        awready_d  = awready_q;
        wready_d   = wready_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        bvalid_d   = bvalid_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        coef_d     = coef_q;
        stats_d    = stats_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;

        if (s_axi_awvalid && awready_q) begin
            awaddr_d  = s_axi_awaddr;
            awready_d = 1'b0;
        end
        if (s_axi_wvalid && wready_q) begin
            wdata_d  = s_axi_wdata[DATA_W-1:0];
            wready_d = 1'b0;
        end
        // Both halves held and no response outstanding: commit the write.
        if (!awready_q && !wready_q && !bvalid_q) begin
            bvalid_d = 1'b1;
            if ((awaddr_q & WORD_MASK) == ADDR_COEF) begin
                coef_d = wdata_q;
            end
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end

        if (s_axi_arvalid && arready_q) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = read_mux(s_axi_araddr, stats_q, coef_q);
        end
        if (rvalid_q && s_axi_rready) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end

        if (s2_valid_q && m_axis_tready) begin
            stats_d = stats_q + 32'd1;
        end

        if (en_c) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_data_q;
            s1_valid_d = s_axis_tvalid;
            s1_data_d  = s_axis_tdata + coef_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            coef_q     <= '0;
            stats_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            coef_q     <= coef_d;
            stats_q    <= stats_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axis_tready = en_c;
    assign m_axis_tdata  = s2_data_q;
    assign m_axis_tvalid = s2_valid_q;

endmodule

// File: tb/tb_pipeline_with_axi_lite.sv
// Bench for pipeline_with_axi_lite: AXI-Lite register access plus randomized
// streaming against a queue-based (sample + COEF) reference model.
module tb_pipeline_with_axi_lite;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;

    int checks   = 0;
    int failures = 0;

    logic [15:0] coef_model;
    logic [31:0] stats_model;
    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];

    pipeline_with_axi_lite #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .ID_VALUE(32'h5049504C),
        .VERSION_VALUE(32'h00010000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clock = ~clock;

    // Called at a falling edge; returns at a falling edge.
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        bit done;
        bit aw_f, w_f, b_f;
        done          = 1'b0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            b_f  = s_axi_bvalid && s_axi_bready;
            if (b_f) begin
                checks++;
                if (s_axi_bresp !== 2'b00) begin
                    failures++;
                    $display("FAIL bresp addr=%h got=%b exp=00", addr, s_axi_bresp);
                end
            end
            @(negedge clock);
            if (aw_f) s_axi_awvalid = 1'b0;
            if (w_f)  s_axi_wvalid  = 1'b0;
            if (b_f)  done = 1'b1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL write_timeout addr=%h got=no_bvalid exp=bvalid", addr);
        end
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done;
        bit ar_f, r_f;
        done          = 1'b0;
        data          = 32'hXXXXXXXX;
        resp          = 2'bXX;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            #1;
            ar_f = s_axi_arvalid && s_axi_arready;
            r_f  = s_axi_rvalid && s_axi_rready;
            if (r_f) begin
                data = s_axi_rdata;
                resp = s_axi_rresp;
            end
            @(negedge clock);
            if (ar_f) s_axi_arvalid = 1'b0;
            if (r_f)  done = 1'b1;
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL read_timeout addr=%h got=no_rvalid exp=rvalid", addr);
        end
    endtask

    task automatic read_expect(input string name, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        checks++;
        if (d !== exp || r !== 2'b00) begin
            failures++;
            $display("FAIL %s addr=%h got=%h/%b exp=%h/00", name, addr, d, r, exp);
        end
    endtask

    // Pushes src_q through the pipeline; model queue holds the expected outputs.
    task automatic run_stream(input string name, input bit rand_hs, output int cycles);
        int n, sent, got, cyc;
        logic [15:0] e;
        n    = src_q.size();
        sent = 0;
        got  = 0;
        cyc  = 0;
        exp_q.delete();
        while (got < n && cyc < 5000) begin
            s_axis_tvalid = (sent < n) && (!rand_hs || ($urandom % 4 != 0));
            s_axis_tdata  = (sent < n) ? src_q[sent] : 16'($urandom);
            m_axis_tready = rand_hs ? 1'($urandom % 2) : 1'b1;
            #1;
            if (m_axis_tvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s spurious_out got=%h exp=none", name, m_axis_tdata);
                end else if (m_axis_tdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL %s out[%0d] got=%h exp=%h", name, got, m_axis_tdata, exp_q[0]);
                end
                if (m_axis_tready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                e = 16'(src_q[sent] + coef_model);
                exp_q.push_back(e);
                sent++;
            end
            @(negedge clock);
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cycles = cyc;
        checks++;
        if (got != n) begin
            failures++;
            $display("FAIL %s beat_count got=%0d exp=%0d", name, got, n);
        end
        stats_model = stats_model + 32'(got);
        repeat (3) @(negedge clock);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s trailing_valid got=%b exp=0", name, m_axis_tvalid);
        end
    endtask

    task automatic set_coef(input logic [31:0] v);
        axi_write(5'hC, v);
        coef_model = v[15:0];
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid, m_axis_tvalid} !== 3'b000 ||
            {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111 ||
            s_axi_rdata !== 32'h0 || m_axis_tdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got=v%b r%b rd=%h td=%h exp=v000 r111 rd=0 td=0",
                     {s_axi_bvalid, s_axi_rvalid, m_axis_tvalid},
                     {s_axi_awready, s_axi_wready, s_axi_arready}, s_axi_rdata, m_axis_tdata);
        end
        reset = 1'b0;
        coef_model  = 16'h0;
        stats_model = 32'h0;
        @(negedge clock);
    endtask

    task automatic test_regmap;
        read_expect("id",          5'h0, 32'h5049504C);
        read_expect("version",     5'h4, 32'h00010000);
        read_expect("stats_reset", 5'h8, 32'h0);
        read_expect("coef_reset",  5'hC, 32'h0);
    endtask

    task automatic test_coef_stream;
        int cyc;
        set_coef(32'hABCD0007);
        read_expect("coef_upper_zero", 5'hC, 32'h00000007);
        set_coef(32'h1);
        read_expect("coef_one", 5'hE, 32'h00000001);
        src_q = '{16'd0, 16'd1, 16'd2, 16'd99, 16'd100, 16'd65534, 16'd65535};
        run_stream("stream_coef1", 1'b0, cyc);
        read_expect("stats_7", 5'h8, stats_model);
    endtask

    task automatic test_wrap;
        int cyc;
        set_coef(32'h10);
        src_q = '{16'hFFF8};
        run_stream("wrap_fff8", 1'b0, cyc);
        set_coef(32'h0);
        src_q = '{16'h1234};
        run_stream("passthru", 1'b0, cyc);
    endtask

    task automatic test_backpressure;
        int cyc;
        set_coef(32'h1);
        src_q.delete();
        for (int i = 0; i < 20; i++) src_q.push_back(16'($urandom));
        src_q[5] = 16'hFFFF;
        run_stream("backpressure", 1'b1, cyc);
        read_expect("stats_after_bp", 5'h8, stats_model);
    endtask

    task automatic test_back_to_back;
        int cyc;
        set_coef(32'($urandom));
        src_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back(16'($urandom));
        run_stream("back_to_back", 1'b0, cyc);
        checks++;
        if (cyc > 34) begin
            failures++;
            $display("FAIL throughput got=%0d cycles exp<=34", cyc);
        end
        read_expect("stats_after_b2b", 5'h8, stats_model);
    endtask

    task automatic test_readonly_unmapped;
        axi_write(5'h0, 32'hDEADBEEF);
        axi_write(5'h8, 32'h12345678);
        axi_write(5'h1C, 32'h0000BEEF);
        read_expect("id_after_write",    5'h0,  32'h5049504C);
        read_expect("stats_after_write", 5'h8,  stats_model);
        read_expect("coef_after_unmapped_write", 5'hC, 32'(coef_model));
        read_expect("unmapped_10",       5'h10, 32'h0);
        read_expect("unmapped_14",       5'h14, 32'h0);
    endtask

    task automatic test_reset_midstream;
        set_coef(32'h5);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h0100;
        @(negedge clock);
        s_axis_tdata  = 16'h0200;
        @(negedge clock);
        s_axis_tvalid = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0105) begin
            failures++;
            $display("FAIL inflight got=%b/%h exp=1/0105", m_axis_tvalid, m_axis_tdata);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_valid got=%b exp=0", m_axis_tvalid);
        end
        @(negedge clock);
        reset         = 1'b0;
        m_axis_tready = 1'b1;
        coef_model    = 16'h0;
        stats_model   = 32'h0;
        @(negedge clock);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL flushed_after_reset got=%b exp=0", m_axis_tvalid);
        end
        read_expect("stats_after_reset", 5'h8, 32'h0);
        read_expect("coef_after_reset",  5'hC, 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = 4'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        coef_model    = 16'h0;
        stats_model   = 32'h0;
        @(negedge clock);
        test_reset;
        test_regmap;
        test_coef_stream;
        test_wrap;
        test_backpressure;
        test_back_to_back;
        test_readonly_unmapped;
        test_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
